// File: rtl/gnss_buf_pkg.sv
// Shared constants and read-FSM state type for the GNSS capture buffer RAMs.
// The capture writer and the sample reader both build on these defaults.
package gnss_buf_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int WORD_W_DEF = 8;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sample_unpacker.sv
// Parallel I/Q shift/hold datapath that turns packed words into a serial
// valid/ready sample stream, bit 0 (oldest capture) first.
module sample_unpacker
    import gnss_buf_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              load_last,
    input  logic [WORD_W-1:0] din_i,
    input  logic [WORD_W-1:0] din_q,
    input  logic              smp_ready,
    output logic              smp_valid,
    output logic              smp_i,
    output logic              smp_q,
    output logic              smp_last,
    output logic              hold_valid,
    output logic              xfer
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] sh_i;
    logic [WORD_W-1:0] sh_q;
    logic [WORD_W-1:0] hold_i;
    logic [WORD_W-1:0] hold_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              sh_valid;
    logic              sh_last;
    logic              hold_last;
    logic              word_end;
    logic              load_to_sh;

    assign xfer      = sh_valid & smp_ready;
    assign word_end  = xfer && (bit_cnt == CNT_LAST);
    assign smp_valid = sh_valid;
    assign smp_i     = sh_i[0];
    assign smp_q     = sh_q[0];
    assign smp_last  = sh_valid && sh_last && (bit_cnt == CNT_LAST);

    // A word landing as the current one drains goes straight to the shifter,
    // which keeps the stream gap-free across word boundaries.
    assign load_to_sh = load && (!sh_valid || (word_end && !hold_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_i       <= '0;
            sh_q       <= '0;
            hold_i     <= '0;
            hold_q     <= '0;
            bit_cnt    <= '0;
            sh_valid   <= 1'b0;
            sh_last    <= 1'b0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
        end else if (clr) begin
            sh_i       <= '0;
            sh_q       <= '0;
            bit_cnt    <= '0;
            sh_valid   <= 1'b0;
            sh_last    <= 1'b0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
        end else begin
            if (word_end) begin
                bit_cnt <= '0;
                if (hold_valid) begin
                    sh_i    <= hold_i;
                    sh_q    <= hold_q;
                    sh_last <= hold_last;
                end else if (load_to_sh) begin
                    sh_i    <= din_i;
                    sh_q    <= din_q;
                    sh_last <= load_last;
                end else begin
                    sh_i     <= '0;
                    sh_q     <= '0;
                    sh_last  <= 1'b0;
                    sh_valid <= 1'b0;
                end
            end else if (xfer) begin
                sh_i    <= sh_i >> 1;
                sh_q    <= sh_q >> 1;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (load_to_sh) begin
                sh_i     <= din_i;
                sh_q     <= din_q;
                sh_last  <= load_last;
                sh_valid <= 1'b1;
                bit_cnt  <= '0;
            end

            if (load && !load_to_sh) begin
                hold_i     <= din_i;
                hold_q     <= din_q;
                hold_last  <= load_last;
                hold_valid <= 1'b1;
            end else if (word_end && hold_valid) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sample_buf_reader.sv
// Replays packed 1-bit I/Q capture words from the bbi/bbq RAMs as a serial
// valid/ready sample stream over a wrapping address window.
//
// state | meaning
// IDLE  | no window; waits for start
// PRIME | first word requested, waiting for it to land
// RUN   | streaming samples, fetching ahead into hold
module sample_buf_reader
    import gnss_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_words,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_dout_i,
    input  logic [WORD_W-1:0] mem_dout_q,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              smp_i,
    output logic              smp_q,
    output logic              smp_last,
    output logic              busy,
    output logic              done
);

    rd_state_t         state;
    logic [ADDR_W-1:0] words_left;
    logic [ADDR_W-1:0] next_addr;
    logic              rd_last;
    logic              rd_dly;
    logic              rd_dly_last;
    logic              rif;
    logic              fetch;
    logic              hold_valid;
    logic              smp_xfer;

    // A read is in flight from the issuing edge until its data lands.
    assign rif       = mem_re | rd_dly;
    assign fetch     = (state != IDLE) && (words_left != '0) && !hold_valid && !rif;
    assign next_addr = (mem_addr == ADDR_W'(DEPTH - 1)) ? '0 : mem_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            words_left  <= '0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            rd_last     <= 1'b0;
            rd_dly      <= 1'b0;
            rd_dly_last <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            mem_re      <= 1'b0;
            rd_dly      <= mem_re;
            rd_dly_last <= rd_last;
            if (abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                words_left <= '0;
                rd_dly     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= PRIME;
                            busy       <= 1'b1;
                            mem_re     <= 1'b1;
                            mem_addr   <= start_addr;
                            words_left <= len_words;
                            rd_last    <= (len_words == '0);
                        end
                    end
                    PRIME, RUN: begin
                        if (fetch) begin
                            mem_re     <= 1'b1;
                            mem_addr   <= next_addr;
                            words_left <= words_left - ADDR_W'(1);
                            rd_last    <= (words_left == ADDR_W'(1));
                        end
                        if (state == PRIME && rd_dly) begin
                            state <= RUN;
                        end
                        if (state == RUN && smp_xfer && smp_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    sample_unpacker #(
        .WORD_W(WORD_W)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .load      (rd_dly),
        .load_last (rd_dly_last),
        .din_i     (mem_dout_i),
        .din_q     (mem_dout_q),
        .smp_ready (smp_ready),
        .smp_valid (smp_valid),
        .smp_i     (smp_i),
        .smp_q     (smp_q),
        .smp_last  (smp_last),
        .hold_valid(hold_valid),
        .xfer      (smp_xfer)
    );

endmodule

// File: tb/tb_sample_buf_reader.sv
// Directed bench for sample_buf_reader with a behavioural registered-read RAM.
module tb_sample_buf_reader;

    localparam int AW    = 14;
    localparam int WW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] len_words;
    logic          abort;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [WW-1:0] mem_dout_i;
    logic [WW-1:0] mem_dout_q;
    logic          smp_valid;
    logic          smp_ready;
    logic          smp_i;
    logic          smp_q;
    logic          smp_last;
    logic          busy;
    logic          done;

    logic [WW-1:0] ram_i [DEPTH];
    logic [WW-1:0] ram_q [DEPTH];
    logic [7:0]    cap_i;
    logic [7:0]    cap_q;
    int            n_chk  = 0;
    int            n_fail = 0;

    sample_buf_reader #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .len_words (len_words),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_dout_i(mem_dout_i),
        .mem_dout_q(mem_dout_q),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_i     (smp_i),
        .smp_q     (smp_q),
        .smp_last  (smp_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_dout_i <= ram_i[mem_addr];
            mem_dout_q <= ram_q[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 32'({mem_addr, mem_re, smp_valid, smp_i, smp_q, smp_last, busy, done}), 32'd0);
    endtask

    // Runs one window from sa; abort_at >= 0 aborts after that many handshakes,
    // dbl_start pulses a second start mid-window.
    task automatic run_window(input int sa, input int nwords, input int pct,
                              input int abort_at, input bit dbl_start);
        int         total = nwords * WW;
        int         idx   = 0;
        int         nrd   = 1;
        int         cyc   = 0;
        int         w;
        int         b;
        bit         fin   = 1'b0;
        bit         rdy;
        bit         pend  = 1'b0;
        logic [3:0] pend_vec = '0;
        logic [7:0] wi;
        logic [7:0] wq;

        start      = 1'b1;
        start_addr = AW'(sa);
        len_words  = AW'(nwords - 1);
        step();
        start = 1'b0;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_re", 32'(mem_re), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'(sa));
        step();
        chk("lat_valid_k1", 32'(smp_valid), 32'd0);
        chk("lat_re_k1", 32'(mem_re), 32'd0);
        step();
        chk("lat_valid_k2", 32'(smp_valid), 32'd1);

        while (!fin && cyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                abort     = 1'b1;
                smp_ready = 1'b0;
                step();
                abort = 1'b0;
                chk("abort_valid", 32'(smp_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_re", 32'(mem_re), 32'd0);
                for (int i = 0; i < 6; i++) begin
                    step();
                    chk("abort_no_done", 32'({done, smp_valid, busy}), 32'd0);
                end
                return;
            end
            rdy       = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
            smp_ready = rdy;
            if (dbl_start && cyc == 3) begin
                start      = 1'b1;
                start_addr = AW'(sa + 1000);
                len_words  = '0;
            end else begin
                start = 1'b0;
            end
            if (pend) begin
                chk("stable", 32'({smp_valid, smp_i, smp_q, smp_last}), 32'(pend_vec));
            end
            if (mem_re) begin
                chk("rd_addr", 32'(mem_addr), 32'((sa + nrd) % DEPTH));
                nrd++;
                chk("rd_count", 32'(nrd <= nwords), 32'd1);
            end
            chk("outstanding", 32'((nrd - idx / WW) <= 2), 32'd1);
            chk("no_done", 32'(done), 32'd0);
            if (smp_valid && rdy) begin
                w  = (sa + idx / WW) % DEPTH;
                b  = idx % WW;
                wi = ram_i[w];
                wq = ram_q[w];
                chk("sample", 32'({smp_i, smp_q, smp_last}),
                    32'({wi[b], wq[b], idx == total - 1}));
                if (idx < 8) begin
                    cap_i[idx] = smp_i;
                    cap_q[idx] = smp_q;
                end
                idx++;
            end else if (pct >= 100 && idx > 0 && idx < total) begin
                chk("no_gap", 32'(smp_valid), 32'd1);
            end
            pend     = smp_valid && !rdy;
            pend_vec = {1'b1, smp_i, smp_q, smp_last};
            step();
            cyc++;
            if (idx == total) fin = 1'b1;
        end
        start = 1'b0;
        chk("window_samples", 32'(idx), 32'(total));
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(smp_valid), 32'd0);
        step();
        chk("done_pulse", 32'(done), 32'd0);
        smp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        len_words  = '0;
        smp_ready  = 1'b0;
        mem_dout_i = '0;
        mem_dout_q = '0;
        cap_i      = '0;
        cap_q      = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ram_i[a] = 8'(a * 37 + 11) ^ 8'(a >> 8);
            ram_q[a] = 8'(a * 91 + 5);
        end
        ram_i[5] = 8'hA5;
        ram_q[5] = 8'h3C;

        step();
        step();
        chk_reset_outputs("reset_state");
        rst = 1'b1;
        step();

        // start and abort together while idle: stays idle
        start      = 1'b1;
        abort      = 1'b1;
        start_addr = 14'd7;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'({busy, mem_re}), 32'd0);
        step();
        chk("start_abort_valid", 32'({busy, smp_valid}), 32'd0);

        run_window(5, 1, 100, -1, 1'b0);
        chk("basic_i", 32'(cap_i), 32'h0000_00A5);
        chk("basic_q", 32'(cap_q), 32'h0000_003C);

        run_window(16382, 4, 100, -1, 1'b0);
        run_window(100, 4, 50, -1, 1'b0);
        run_window(200, 4, 100, 11, 1'b0);
        run_window(300, 2, 100, -1, 1'b0);
        run_window(40, 3, 100, -1, 1'b1);

        // reset mid-window
        start      = 1'b1;
        start_addr = 14'd60;
        len_words  = 14'd3;
        step();
        start     = 1'b0;
        smp_ready = 1'b1;
        repeat (6) step();
        chk("pre_rst_busy", 32'({busy, smp_valid}), 32'd3);
        #3 rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        rst       = 1'b1;
        smp_ready = 1'b0;
        step();
        chk("post_rst_idle", 32'({busy, smp_valid, done}), 32'd0);

        run_window(5, 1, 100, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
